digit_scan_sched: RTL and testbench



---
 rtl/digit_scan_sched_if.sv | 25 ++
 rtl/digit_scan_sched.sv | 157 +++++++++++++++
 tb/tb_digit_scan_sched.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_scan_sched_if.sv
// rtl/digit_scan_sched_if.sv - display-source and anode bundle for the 7-segment scan scheduler
interface digit_scan_sched_if;
  logic [31:0] a_digits;
  logic        lzb;
  logic        b_req;
  logic [31:0] b_digits;
  logic [7:0]  b_frames;
  logic        b_ack;
  logic        b_done;
  logic        owner_b;
  logic        frame_start;
  logic [3:0]  digit_data;
  logic        digit_blank;
  logic [7:0]  DIGIT;

  modport master (
    output a_digits, lzb, b_req, b_digits, b_frames,
    input  b_ack, b_done, owner_b, frame_start, digit_data, digit_blank, DIGIT
  );

  modport slave (
    input  a_digits, lzb, b_req, b_digits, b_frames,
    output b_ack, b_done, owner_b, frame_start, digit_data, digit_blank, DIGIT
  );
endinterface

// File: rtl/digit_scan_sched.sv
// rtl/digit_scan_sched.sv - 8-digit anode scan with dead time and two-source frame arbiter
module digit_scan_sched #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic                CLK,
  input logic                RST_N,
  digit_scan_sched_if.slave  bus
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit NO_DEAD = (BLANK_CYCLES == 0);

  typedef enum logic {ST_SCAN, ST_DEAD} state_t;

  state_t        state_q, state_d;
  logic [2:0]    slot_q, slot_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    frames_q, frames_d;
  logic          owner_q, owner_d;
  logic [31:0]   snap_q, snap_d;
  logic [7:0]    digit_q, digit_d;
  logic [3:0]    data_q, data_d;
  logic          blank_q, blank_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic          fs_q, fs_d;

  logic          advance;
  logic [2:0]    slot_next;
  logic          show_b;
  logic [31:0]   snap_src;

  // State register and registered outputs; reset parks in DEAD just before slot 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_DEAD;
      slot_q   <= 3'd7;
      count_q  <= '0;
      frames_q <= 8'd0;
      owner_q  <= 1'b0;
      snap_q   <= 32'd0;
      digit_q  <= 8'hFF;
      data_q   <= 4'd0;
      blank_q  <= 1'b1;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      count_q  <= count_d;
      frames_q <= frames_d;
      owner_q  <= owner_d;
      snap_q   <= snap_d;
      digit_q  <= digit_d;
      data_q   <= data_d;
      blank_q  <= blank_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      fs_q     <= fs_d;
    end
  end

  // Slot/dead-time sequencing, frame-boundary arbitration and per-slot data load.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    count_d   = count_q;
    frames_d  = frames_q;
    owner_d   = owner_q;
    snap_d    = snap_q;
    digit_d   = digit_q;
    data_d    = data_q;
    blank_d   = blank_q;
    ack_d     = 1'b0;
    done_d    = 1'b0;
    fs_d      = 1'b0;
    advance   = 1'b0;
    slot_next = slot_q + 3'd1;
    show_b    = owner_q;
    snap_src  = snap_q;

    case (state_q)
      ST_SCAN: begin
        if (count_q == SCAN_LAST) begin
          if (NO_DEAD) begin
            advance = 1'b1;
          end else begin
            state_d = ST_DEAD;
            count_d = '0;
            digit_d = 8'hFF;
            blank_d = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        if (NO_DEAD || count_q == BLANK_LAST) begin
          advance = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
    endcase

    if (advance) begin
      state_d = ST_SCAN;
      count_d = '0;
      slot_d  = slot_next;
      digit_d = ~(8'b1 << slot_next);

      // Ownership only changes as digit 0 is lit; a release always yields
      // at least one A frame because the grant branch is skipped that edge.
      if (slot_next == 3'd0) begin
        fs_d = 1'b1;
        if (owner_q) begin
          frames_d = frames_q - 8'd1;
          if (frames_q <= 8'd1) begin
            owner_d = 1'b0;
            done_d  = 1'b1;
            show_b  = 1'b0;
          end
        end else if (bus.b_req) begin
          ack_d    = 1'b1;
          owner_d  = 1'b1;
          show_b   = 1'b1;
          snap_d   = bus.b_digits;
          snap_src = bus.b_digits;
          frames_d = (bus.b_frames == 8'd0) ? 8'd1 : bus.b_frames;
        end
      end

      if (show_b) begin
        data_d  = snap_src[{slot_next, 2'b00} +: 4];
        blank_d = 1'b0;
      end else begin
        data_d  = bus.a_digits[{slot_next, 2'b00} +: 4];
        blank_d = bus.lzb && (slot_next != 3'd0) &&
                  ((bus.a_digits >> {slot_next, 2'b00}) == 32'd0);
      end
    end
  end

  assign bus.DIGIT       = digit_q;
  assign bus.digit_data  = data_q;
  assign bus.digit_blank = blank_q;
  assign bus.b_ack       = ack_q;
  assign bus.b_done      = done_q;
  assign bus.owner_b     = owner_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_digit_scan_sched.sv
// tb/tb_digit_scan_sched.sv - scoreboard bench for digit_scan_sched with and without dead time
module tb_digit_scan_sched;

  localparam int SD0 = 4;
  localparam int BC0 = 2;
  localparam int SD1 = 3;
  localparam int BC1 = 0;

  typedef struct {
    logic [7:0] digit;
    logic [3:0] data;
    logic       blank;
    logic       owner;
    logic       ack;
    logic       done;
    logic       fs;
    logic       pre;
  } exp_t;

  typedef struct {
    int          t;
    bit          owner;
    int          frames;
    logic [31:0] snap;
    logic [3:0]  data;
    logic        blank;
  } mst_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_digits = 32'h76543210;
  logic        lzb = 1'b0;
  logic        b_req = 1'b0;
  logic [31:0] b_digits = 32'd0;
  logic [7:0]  b_frames = 8'd0;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];
  mst_t m0, m1;

  digit_scan_sched_if if0 ();
  digit_scan_sched_if if1 ();

  assign if0.a_digits = a_digits;
  assign if0.lzb      = lzb;
  assign if0.b_req    = b_req;
  assign if0.b_digits = b_digits;
  assign if0.b_frames = b_frames;
  assign if1.a_digits = a_digits;
  assign if1.lzb      = lzb;
  assign if1.b_req    = b_req;
  assign if1.b_digits = b_digits;
  assign if1.b_frames = b_frames;

  digit_scan_sched #(.SCAN_DIV(SD0), .BLANK_CYCLES(BC0)) dut0 (.CLK(clk), .RST_N(rst_n), .bus(if0));
  digit_scan_sched #(.SCAN_DIV(SD1), .BLANK_CYCLES(BC1)) dut1 (.CLK(clk), .RST_N(rst_n), .bus(if1));

  always #5 clk = ~clk;

  function automatic mst_t model_reset();
    mst_t s;
    s.t = 0; s.owner = 1'b0; s.frames = 0; s.snap = 32'd0; s.data = 4'd0; s.blank = 1'b1;
    return s;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.digit = 8'hFF; e.data = 4'd0; e.blank = 1'b1; e.owner = 1'b0;
    e.ack = 1'b0; e.done = 1'b0; e.fs = 1'b0; e.pre = 1'b1;
    return e;
  endfunction

  // Timeline model: position in the frame follows from the edge count since reset.
  function automatic void model_step(input int sd, input int bc, input mst_t si, output mst_t so,
                                     input logic [31:0] a, input logic l, input logic req,
                                     input logic [31:0] bd, input logic [7:0] bf, output exp_t e);
    int period, eidx, p, slot;
    mst_t s;
    s = si;
    s.t++;
    period = sd + bc;
    eidx = s.t - ((bc > 0) ? bc : 1);
    e = reset_exp();
    if (eidx >= 0) begin
      e.pre = 1'b0;
      p = eidx % period;
      slot = (eidx / period) % 8;
      if (p == 0) begin
        if (slot == 0) begin
          e.fs = 1'b1;
          if (s.owner) begin
            s.frames--;
            if (s.frames == 0) begin
              s.owner = 1'b0;
              e.done = 1'b1;
            end
          end else if (req) begin
            s.owner = 1'b1;
            e.ack = 1'b1;
            s.snap = bd;
            s.frames = (bf == 8'd0) ? 1 : int'(bf);
          end
        end
        if (s.owner) begin
          s.data = 4'((s.snap >> (4 * slot)) & 32'hF);
          s.blank = 1'b0;
        end else begin
          s.data = 4'((a >> (4 * slot)) & 32'hF);
          s.blank = l && (slot != 0) && ((a >> (4 * slot)) == 32'd0);
        end
      end
      if (p < sd) begin
        e.digit = ~(8'b1 << slot);
        e.blank = s.blank;
      end
    end
    e.data = s.data;
    e.owner = s.owner;
    so = s;
  endfunction

  task automatic check_out(input string name, input exp_t e, input logic [7:0] dg, input logic [3:0] dd,
                           input logic db, input logic ow, input logic ak, input logic dn, input logic fs);
    logic [16:0] ev, av;
    logic cmp_data;
    cmp_data = (e.digit != 8'hFF) || e.pre;
    ev = {e.digit, cmp_data ? e.data : 4'd0, e.blank, e.owner, e.ack, e.done, e.fs};
    av = {dg, cmp_data ? dd : 4'd0, db, ow, ak, dn, fs};
    n_cmp++;
    if (ev !== av) begin
      n_bad++;
      $display("FAIL %s @%0t: got digit=%h data=%h blank=%b own=%b ack=%b done=%b fs=%b, want digit=%h data=%h blank=%b own=%b ack=%b done=%b fs=%b",
               name, $time, dg, dd, db, ow, ak, dn, fs,
               e.digit, e.data, e.blank, e.owner, e.ack, e.done, e.fs);
    end
  endtask

  task automatic check_now();
    check_out("dut0_reset_async", reset_exp(), if0.DIGIT, if0.digit_data, if0.digit_blank,
              if0.owner_b, if0.b_ack, if0.b_done, if0.frame_start);
    check_out("dut1_reset_async", reset_exp(), if1.DIGIT, if1.digit_data, if1.digit_blank,
              if1.owner_b, if1.b_ack, if1.b_done, if1.frame_start);
  endtask

  // Reference model: produce the expected post-edge outputs from pre-edge inputs.
  always @(posedge clk) begin
    exp_t e0, e1;
    mst_t n0, n1;
    if (!rst_n) begin
      m0 = model_reset();
      m1 = model_reset();
    end else begin
      model_step(SD0, BC0, m0, n0, a_digits, lzb, b_req, b_digits, b_frames, e0);
      model_step(SD1, BC1, m1, n1, a_digits, lzb, b_req, b_digits, b_frames, e1);
      m0 = n0;
      m1 = n1;
      q0.push_back(e0);
      q1.push_back(e1);
    end
  end

  // Monitor: away from the active edge, pop and compare each instance's outputs.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      check_out("dut0_reset", reset_exp(), if0.DIGIT, if0.digit_data, if0.digit_blank,
                if0.owner_b, if0.b_ack, if0.b_done, if0.frame_start);
      check_out("dut1_reset", reset_exp(), if1.DIGIT, if1.digit_data, if1.digit_blank,
                if1.owner_b, if1.b_ack, if1.b_done, if1.frame_start);
    end else begin
      if (q0.size() == 0 || q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_underflow @%0t: got q0=%0d q1=%0d entries, want >0", $time, q0.size(), q1.size());
      end else begin
        e = q0.pop_front();
        check_out("dut0", e, if0.DIGIT, if0.digit_data, if0.digit_blank,
                  if0.owner_b, if0.b_ack, if0.b_done, if0.frame_start);
        e = q1.pop_front();
        check_out("dut1", e, if1.DIGIT, if1.digit_data, if1.digit_blank,
                  if1.owner_b, if1.b_ack, if1.b_done, if1.frame_start);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_flag(input string name, input int which, input int budget);
    int k = 0;
    while (k < budget && !((which == 0) ? if0.b_ack : if0.owner_b)) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no event within %0d cycles, want event", name, budget);
    end
  endtask

  initial begin
    m0 = model_reset();
    m1 = model_reset();
    run(3);
    #2 rst_n = 1'b1;

    // Plain scan of 76543210.
    run(120);

    // Leading-zero blanking variants.
    a_digits = 32'h00000305; lzb = 1'b1; run(100);
    lzb = 1'b0; run(60);
    a_digits = 32'h00000000; lzb = 1'b1; run(60);

    // Overlay raised mid-frame for two frames.
    a_digits = 32'h76543210; lzb = 1'b0; run(20);
    b_digits = 32'hAAAAAAAA; b_frames = 8'd2; b_req = 1'b1;
    wait_flag("overlay_ack", 0, 100);
    b_req = 1'b0; run(200);

    // Fairness with a continuously held request.
    b_digits = 32'h9876FEDC; b_frames = 8'd1; b_req = 1'b1; run(250);
    b_req = 1'b0; run(100);

    // Zero frame count acts as one frame.
    b_digits = 32'hBBBB1234; b_frames = 8'd0; b_req = 1'b1;
    wait_flag("zero_frames_ack", 0, 100);
    b_req = 1'b0; run(150);

    // Randomised mix of sources, blanking and requests.
    for (int i = 0; i < 60; i++) begin
      a_digits = $urandom >> (4 * $urandom_range(0, 8));
      lzb      = 1'($urandom_range(0, 1));
      b_req    = ($urandom_range(0, 3) == 0);
      b_digits = $urandom;
      b_frames = 8'($urandom_range(0, 3));
      run($urandom_range(5, 60));
    end
    b_req = 1'b0; run(60);

    // Asynchronous reset while B owns the display, mid-slot.
    b_digits = 32'hCCCCCCCC; b_frames = 8'd3; b_req = 1'b1;
    wait_flag("owner_before_reset", 1, 200);
    b_req = 1'b0; run(7);
    #3 rst_n = 1'b0;
    #1 check_now();
    run(2);
    a_digits = 32'h76543210; lzb = 1'b0;
    #2 rst_n = 1'b1;
    run(120);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
